// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: holds the PLL in reset, waits for and qualifies lock,
// measures the output frequency through a divided toggle flag, and gates the
// core reset on the outcome.
module pll_lock_supervisor #(
  parameter int unsigned RST_CYCLES    = 32,
  parameter int unsigned LOCK_TIMEOUT  = 500000,
  parameter int unsigned STABLE_CYCLES = 65536,
  parameter int unsigned WINDOW        = 1048576,
  parameter int unsigned EXP_MIN       = 686,
  parameter int unsigned EXP_MAX       = 701,
  parameter int unsigned CNT_W         = 16
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             locked,
  input  logic             clk_toggle,
  output logic             pll_rst,
  output logic             core_reset,
  output logic             freq_ok,
  output logic [CNT_W-1:0] edge_count,
  output logic [7:0]       lock_lost_cnt,
  output logic [7:0]       retry_cnt,
  output logic [2:0]       state
);

  localparam int unsigned MAX_AB = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int unsigned MAX_CD = (STABLE_CYCLES > WINDOW) ? STABLE_CYCLES : WINDOW;
  localparam int unsigned MAX_T  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int unsigned TMR_W  = $clog2(MAX_T + 1);

  typedef enum logic [2:0] {
    S_PLLRST   = 3'd0,
    S_WAITLOCK = 3'd1,
    S_STABLE   = 3'd2,
    S_MEASURE  = 3'd3,
    S_RUN      = 3'd4
  } state_t;

  state_t           st;
  logic [TMR_W-1:0] timer;
  logic [1:0]       lk_sync;
  logic [2:0]       tg_sync;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             lk_s;
  logic             tg_edge;
  logic             in_range;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign lk_s    = lk_sync[1];
  assign tg_edge = tg_sync[1] ^ tg_sync[2];
  assign state   = 3'(st);

  // Saturating edge count including any edge on the current cycle, and its range check
  always_comb begin
    cnt_next = cnt;
    if (tg_edge && (cnt != {CNT_W{1'b1}})) begin
      cnt_next = cnt + CNT_W'(1);
    end
    in_range = (cnt_next >= CNT_W'(EXP_MIN)) && (cnt_next <= CNT_W'(EXP_MAX));
  end

  // Synchronizers, timer, edge counter and supervisor FSM with registered outputs
  always_ff @(posedge refclk) begin
    if (rst) begin
      st            <= S_PLLRST;
      timer         <= '0;
      lk_sync       <= '0;
      tg_sync       <= '0;
      cnt           <= '0;
      pll_rst       <= 1'b1;
      core_reset    <= 1'b1;
      freq_ok       <= 1'b0;
      edge_count    <= '0;
      lock_lost_cnt <= '0;
      retry_cnt     <= '0;
    end else begin
      lk_sync <= {lk_sync[0], locked};
      tg_sync <= {tg_sync[1:0], clk_toggle};
      timer   <= timer + TMR_W'(1);
      case (st)
        S_PLLRST: begin
          if (timer == TMR_W'(RST_CYCLES - 1)) begin
            st      <= S_WAITLOCK;
            pll_rst <= 1'b0;
            timer   <= '0;
          end
        end
        S_WAITLOCK: begin
          if (lk_s) begin
            st    <= S_STABLE;
            timer <= '0;
          end else if (timer == TMR_W'(LOCK_TIMEOUT - 1)) begin
            st        <= S_PLLRST;
            pll_rst   <= 1'b1;
            retry_cnt <= sat_inc(retry_cnt);
            timer     <= '0;
          end
        end
        S_STABLE: begin
          if (!lk_s) begin
            st            <= S_PLLRST;
            pll_rst       <= 1'b1;
            lock_lost_cnt <= sat_inc(lock_lost_cnt);
            timer         <= '0;
          end else if (timer == TMR_W'(STABLE_CYCLES - 1)) begin
            st    <= S_MEASURE;
            cnt   <= '0;
            timer <= '0;
          end
        end
        S_MEASURE: begin
          if (!lk_s) begin
            st            <= S_PLLRST;
            pll_rst       <= 1'b1;
            lock_lost_cnt <= sat_inc(lock_lost_cnt);
            timer         <= '0;
          end else begin
            cnt <= cnt_next;
            if (timer == TMR_W'(WINDOW - 1)) begin
              edge_count <= cnt_next;
              timer      <= '0;
              if (in_range) begin
                st         <= S_RUN;
                freq_ok    <= 1'b1;
                core_reset <= 1'b0;
              end else begin
                st        <= S_PLLRST;
                freq_ok   <= 1'b0;
                pll_rst   <= 1'b1;
                retry_cnt <= sat_inc(retry_cnt);
              end
            end
          end
        end
        S_RUN: begin
          timer <= '0;
          if (!lk_s) begin
            st            <= S_PLLRST;
            pll_rst       <= 1'b1;
            core_reset    <= 1'b1;
            freq_ok       <= 1'b0;
            lock_lost_cnt <= sat_inc(lock_lost_cnt);
          end
        end
        default: begin
          st         <= S_PLLRST;
          pll_rst    <= 1'b1;
          core_reset <= 1'b1;
          freq_ok    <= 1'b0;
          timer      <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor using reduced timing parameters.
module tb_pll_lock_supervisor;

  localparam int unsigned CNT_W = 16;

  logic             refclk = 1'b0;
  logic             rst = 1'b1;
  logic             locked = 1'b0;
  logic             clk_toggle = 1'b0;
  logic             pll_rst;
  logic             core_reset;
  logic             freq_ok;
  logic [CNT_W-1:0] edge_count;
  logic [7:0]       lock_lost_cnt;
  logic [7:0]       retry_cnt;
  logic [2:0]       state;

  pll_lock_supervisor #(
    .RST_CYCLES(4), .LOCK_TIMEOUT(100), .STABLE_CYCLES(16),
    .WINDOW(256), .EXP_MIN(10), .EXP_MAX(12), .CNT_W(CNT_W)
  ) dut (
    .refclk(refclk), .rst(rst), .locked(locked), .clk_toggle(clk_toggle),
    .pll_rst(pll_rst), .core_reset(core_reset), .freq_ok(freq_ok),
    .edge_count(edge_count), .lock_lost_cnt(lock_lost_cnt),
    .retry_cnt(retry_cnt), .state(state)
  );

  always #10 refclk = ~refclk;

  typedef struct {
    int period;
    int exp_cnt;
    int exp_ok;
    int exp_state;
    int exp_retry;
    int exp_core;
  } vec_t;

  vec_t tbl[6];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   lock_at = 0;
  int   period = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One refclk cycle; inputs change and outputs are sampled on the falling edge
  task automatic step();
    @(negedge refclk);
    cyc++;
    if (lock_at != 0 && cyc == lock_at) locked = 1'b1;
    if (period != 0 && lock_at != 0 && cyc > lock_at && ((cyc - lock_at) % period) == 0)
      clk_toggle = ~clk_toggle;
  endtask

  task automatic run_to(input int target);
    while (cyc < target) step();
  endtask

  // Leaves the bench on the falling edge right after the last reset edge (cycle 0)
  task automatic do_reset(input int la, input int p);
    rst = 1'b1;
    locked = 1'b0;
    clk_toggle = 1'b0;
    period = 0;
    lock_at = 0;
    repeat (3) @(negedge refclk);
    rst = 1'b0;
    cyc = 0;
    lock_at = la;
    period = p;
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int core_low;
    tbl[0] = '{23, 11, 1, 4, 0, 0};
    tbl[1] = '{40,  6, 0, 0, 1, 1};
    tbl[2] = '{25, 10, 1, 4, 0, 0};
    tbl[3] = '{21, 12, 1, 4, 0, 0};
    tbl[4] = '{20, 13, 0, 0, 1, 1};
    tbl[5] = '{28,  9, 0, 0, 1, 1};

    // Reset values and normal bring-up
    do_reset(10, 23);
    chk("rst_state", state, 0);
    chk("rst_pll_rst", pll_rst, 1);
    chk("rst_core_reset", core_reset, 1);
    chk("rst_freq_ok", freq_ok, 0);
    chk("rst_edge_count", edge_count, 0);
    chk("rst_lock_lost", lock_lost_cnt, 0);
    chk("rst_retry", retry_cnt, 0);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      if (pll_rst) n++;
      step();
    end
    chk("pll_rst_len", n, 4);
    run_to(12);
    chk("waitlock_state", state, 1);
    run_to(13);
    chk("stable_entry", state, 2);
    run_to(28);
    chk("stable_last", state, 2);
    run_to(29);
    chk("measure_entry", state, 3);
    run_to(285);
    chk("bringup_state", state, 4);
    chk("bringup_edges", edge_count, 11);
    chk("bringup_freq_ok", freq_ok, 1);
    chk("bringup_core_reset", core_reset, 0);

    // Loss of lock in RUN: core_reset rises three cycles after the input edge
    run_to(300);
    period = 0;
    locked = 1'b0;
    step();
    step();
    chk("run_loss_core_c2", core_reset, 0);
    step();
    chk("run_loss_core_c3", core_reset, 1);
    chk("run_loss_freq_ok", freq_ok, 0);
    chk("run_loss_lost", lock_lost_cnt, 1);
    chk("run_loss_pll_rst", pll_rst, 1);
    chk("run_loss_state", state, 0);
    chk("run_loss_edges_kept", edge_count, 11);

    // Reset in the middle of a measurement window
    locked = 1'b1;
    n = 0;
    while (state != 3'd3 && n < 100) begin
      step();
      n++;
    end
    chk("reach_measure", state, 3);
    repeat (10) step();
    chk("mid_measure_edges", edge_count, 11);
    rst = 1'b1;
    step();
    chk("midrst_state", state, 0);
    chk("midrst_pll_rst", pll_rst, 1);
    chk("midrst_core_reset", core_reset, 1);
    chk("midrst_freq_ok", freq_ok, 0);
    chk("midrst_edge_count", edge_count, 0);
    chk("midrst_lock_lost", lock_lost_cnt, 0);
    chk("midrst_retry", retry_cnt, 0);

    // Measurement window outcomes across toggle rates
    for (int v = 0; v < 6; v++) begin
      do_reset(10, tbl[v].period);
      core_low = 0;
      while (cyc < 284) begin
        step();
        if (!core_reset) core_low = 1;
      end
      chk($sformatf("p%0d_core_held", tbl[v].period), core_low, 0);
      chk($sformatf("p%0d_window_state", tbl[v].period), state, 3);
      run_to(285);
      chk($sformatf("p%0d_edges", tbl[v].period), edge_count, tbl[v].exp_cnt);
      chk($sformatf("p%0d_freq_ok", tbl[v].period), freq_ok, tbl[v].exp_ok);
      chk($sformatf("p%0d_state", tbl[v].period), state, tbl[v].exp_state);
      chk($sformatf("p%0d_retry", tbl[v].period), retry_cnt, tbl[v].exp_retry);
      chk($sformatf("p%0d_core_reset", tbl[v].period), core_reset, tbl[v].exp_core);
      chk($sformatf("p%0d_lost", tbl[v].period), lock_lost_cnt, 0);
    end

    // One-cycle lock glitch during STABLE
    do_reset(10, 0);
    core_low = 0;
    run_to(15);
    locked = 1'b0;
    step();
    locked = 1'b1;
    run_to(17);
    chk("glitch_pre_state", state, 2);
    step();
    chk("glitch_state", state, 0);
    chk("glitch_lost", lock_lost_cnt, 1);
    while (cyc < 60) begin
      if (!core_reset) core_low = 1;
      step();
    end
    chk("glitch_core_held", core_low, 0);

    // Lock timeout retries and retry counter saturation
    do_reset(0, 0);
    run_to(103);
    chk("timeout_pre_state", state, 1);
    chk("timeout_pre_retry", retry_cnt, 0);
    run_to(104);
    chk("timeout_state", state, 0);
    chk("timeout_retry", retry_cnt, 1);
    n = 0;
    for (int i = 0; i < 8; i++) begin
      if (pll_rst) n++;
      step();
    end
    chk("timeout_pll_rst_len", n, 4);
    run_to(26519);
    chk("retry_254", retry_cnt, 254);
    run_to(26520);
    chk("retry_255", retry_cnt, 255);
    run_to(31200);
    chk("retry_sat", retry_cnt, 255);
    chk("retry_sat_state", state, 0);
    chk("retry_core_reset", core_reset, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
